// File: rtl/bloom_filter_arbiter_pkg.sv
// Shared types and widths for the bloom-filter lookup arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package bf_arb_pkg;

    localparam int TUPLE_W  = 104;
    localparam int IP_PRO_W = 72;
    localparam int PORT_W   = 16;

    // One flow-lookup key as presented to the filter
    typedef struct packed {
        logic [IP_PRO_W-1:0] ip_pro;
        logic [PORT_W-1:0]   src_port;
        logic [PORT_W-1:0]   dest_port;
    } bf_tuple_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bf_arb_state_e;

endpackage

// File: rtl/bloom_filter_arbiter_if.sv
// Requester, response and filter-side signals of the lookup arbiter.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready, rsp_valid/rsp_ready, bf_readyRecv gates bf_start.
interface bloom_filter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    // requester side
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*bf_arb_pkg::IP_PRO_W-1:0] req_ip_pro;
    logic [NUM_REQ*bf_arb_pkg::PORT_W-1:0]   req_src_port;
    logic [NUM_REQ*bf_arb_pkg::PORT_W-1:0]   req_dest_port;
    // response side
    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [ID_W-1:0]                        rsp_id;
    logic                                   rsp_hit;
    logic                                   rsp_err;
    // filter side
    logic [bf_arb_pkg::IP_PRO_W-1:0]         bf_ip_pro;
    logic [bf_arb_pkg::PORT_W-1:0]           bf_src_port;
    logic [bf_arb_pkg::PORT_W-1:0]           bf_dest_port;
    logic                                   bf_start;
    logic                                   bf_readyRecv;
    logic                                   bf_readyRes;
    logic                                   bf_get_Result;

    // master: the arbiter itself
    modport master (
        input  req_valid, req_ip_pro, req_src_port, req_dest_port,
        input  rsp_ready, bf_readyRecv, bf_readyRes, bf_get_Result,
        output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_err,
        output bf_ip_pro, bf_src_port, bf_dest_port, bf_start
    );

    // slave: requesters, response consumer and filter around it
    modport slave (
        output req_valid, req_ip_pro, req_src_port, req_dest_port,
        output rsp_ready, bf_readyRecv, bf_readyRes, bf_get_Result,
        input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_err,
        input  bf_ip_pro, bf_src_port, bf_dest_port, bf_start
    );

endinterface

// File: rtl/bloom_filter_arbiter_rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int          pos;
    logic [ID_W-1:0] pos_idx;

    // Scan NUM_REQ positions starting at the pointer; first hit wins
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = pos[ID_W-1:0];
            if (!any_o && req_i[pos_idx]) begin
                any_o          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/bloom_filter_arbiter.sv
// Shares one bloom-filter engine among NUM_REQ requesters, one lookup in flight.
// Latency: grant c0, bf_start c1 (if readyRecv), rsp_valid one cycle after readyRes.
// Backpressure: holds tuple while readyRecv=0, holds response while rsp_ready=0; BF_ARB_TIMEOUT_EN adds a WAIT timeout.
module bloom_filter_arbiter
    import bf_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    bloom_filter_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TUPLE_W-1:0] tuple_q, tuple_d, tuple_sel;
    logic [ID_W-1:0]    id_q, id_d;
    logic               hit_q, hit_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    bf_tuple_t          tuple_s;

`ifdef BF_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC < 1);
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Select the granted requester's tuple from the flat request buses
    always_comb begin
        tuple_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                tuple_sel = {bus.req_ip_pro[i*IP_PRO_W +: IP_PRO_W],
                             bus.req_src_port[i*PORT_W +: PORT_W],
                             bus.req_dest_port[i*PORT_W +: PORT_W]};
            end
        end
    end

    // Lookup sequencer: grant -> issue -> wait for result -> return response
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        tuple_d  = tuple_q;
        id_d     = id_q;
        hit_d    = hit_q;
`ifdef BF_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    tuple_d  = tuple_sel;
                    id_d     = arb_idx;
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.bf_readyRecv) begin
                    state_d = S_WAIT;
`ifdef BF_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (bus.bf_readyRes) begin
                    hit_d   = bus.bf_get_Result;
                    state_d = S_RESP;
`ifdef BF_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                // no grant in the accepting cycle; the next IDLE cycle arbitrates
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any outstanding lookup
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            tuple_q  <= '0;
            id_q     <= '0;
            hit_q    <= 1'b0;
`ifdef BF_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tuple_q  <= tuple_d;
            id_q     <= id_d;
            hit_q    <= hit_d;
`ifdef BF_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign tuple_s = bf_tuple_t'(tuple_q);

    // reset gates req_ready so outputs read zero while reset is held
    assign bus.req_ready    = (reset && state_q == S_IDLE) ? arb_gnt : '0;
    assign bus.bf_start     = (state_q == S_ISSUE) && bus.bf_readyRecv;
    assign bus.bf_ip_pro    = tuple_s.ip_pro;
    assign bus.bf_src_port  = tuple_s.src_port;
    assign bus.bf_dest_port = tuple_s.dest_port;
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_hit      = hit_q;
`ifdef BF_ARB_TIMEOUT_EN
    assign bus.rsp_err      = err_q;
`else
    assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bloom_filter_arbiter.sv
// Scoreboard bench for bloom_filter_arbiter with a behavioural filter model.
// Latency: filter answers fm_delay cycles after bf_start.
// Backpressure: directed stalls on bf_readyRecv and rsp_ready.
module tb_bloom_filter_arbiter;
    import bf_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            hit;
        logic            err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*IP_PRO_W-1:0] req_ip_pro;
    logic [NUM_REQ*PORT_W-1:0] req_src_port;
    logic [NUM_REQ*PORT_W-1:0] req_dest_port;
    logic                      rsp_ready;
    logic                      bf_readyRecv;
    logic                      fm_res = 1'b0;
    logic                      fm_hit = 1'b0;
    logic                      fm_en;
    int                        fm_delay;

    bloom_filter_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    assign bus.req_valid     = req_valid;
    assign bus.req_ip_pro    = req_ip_pro;
    assign bus.req_src_port  = req_src_port;
    assign bus.req_dest_port = req_dest_port;
    assign bus.rsp_ready     = rsp_ready;
    assign bus.bf_readyRecv  = bf_readyRecv;
    assign bus.bf_readyRes   = fm_res;
    assign bus.bf_get_Result = fm_hit;

    bloom_filter_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int        checks = 0;
    int        errors = 0;
    int        exp_gnt_q[$];
    bf_tuple_t exp_bf_q[$];
    rsp_t      exp_rsp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic bf_tuple_t port_tuple(input int p);
        bf_tuple_t t;
        t.ip_pro    = {32'h0A000000 + 32'(p), 32'h0B000000 + 32'(p), 8'd6};
        t.src_port  = 16'(1000 + p);
        t.dest_port = 16'(2000 + p);
        return t;
    endfunction

    // Filter model: hit when source port is even
    logic fm_r;
    always begin
        @(negedge clk);
        if (reset && fm_en && bus.bf_start) begin
            fm_r = !bus.bf_src_port[0];
            repeat (fm_delay) @(posedge clk);
            #1;
            fm_res = 1'b1;
            fm_hit = fm_r;
            @(posedge clk);
            #1;
            fm_res = 1'b0;
            fm_hit = 1'b0;
        end
    end

    // Monitors: grants, filter issues and responses against the expected queues
    int        mon_g;
    bf_tuple_t mon_t;
    rsp_t      mon_r;
    always @(negedge clk) begin
        if (reset) begin
            if (bus.req_ready != '0) begin
                chk("req_ready_onehot", 128'($onehot(bus.req_ready)), 128'(1));
                if (exp_gnt_q.size() == 0) flag("unexpected_grant");
                else begin
                    mon_g = exp_gnt_q.pop_front();
                    chk("grant", 128'(bus.req_ready), 128'(4'b0001 << mon_g));
                end
            end
            if (bus.bf_start) begin
                if (exp_bf_q.size() == 0) flag("unexpected_bf_start");
                else begin
                    mon_t = exp_bf_q.pop_front();
                    chk("bf_tuple", {bus.bf_ip_pro, bus.bf_src_port, bus.bf_dest_port}, 128'(mon_t));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp_q.size() == 0) flag("unexpected_rsp");
                else begin
                    mon_r = exp_rsp_q.pop_front();
                    chk("rsp_id", 128'(bus.rsp_id), 128'(mon_r.id));
                    chk("rsp_hit", 128'(bus.rsp_hit), 128'(mon_r.hit));
                    chk("rsp_err", 128'(bus.rsp_err), 128'(mon_r.err));
                end
            end
        end
    end

    task automatic set_port(input int p, input bf_tuple_t t);
        req_ip_pro[p*IP_PRO_W +: IP_PRO_W] = t.ip_pro;
        req_src_port[p*PORT_W +: PORT_W]   = t.src_port;
        req_dest_port[p*PORT_W +: PORT_W]  = t.dest_port;
    endtask

    task automatic wait_grant(input int p, input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[p] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready[p]) flag($sformatf("grant_timeout port %0d", p));
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic send(input int p, input bf_tuple_t t, input logic hit, input logic err, input bit want_rsp);
        rsp_t r;
        r.id  = ID_W'(p);
        r.hit = hit;
        r.err = err;
        exp_gnt_q.push_back(p);
        exp_bf_q.push_back(t);
        if (want_rsp) exp_rsp_q.push_back(r);
        set_port(p, t);
        req_valid[p] = 1'b1;
        wait_grant(p, 40);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && (exp_gnt_q.size() != 0 || exp_bf_q.size() != 0 ||
                              exp_rsp_q.size() != 0 || bus.rsp_valid)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 128'(exp_gnt_q.size() + exp_bf_q.size() + exp_rsp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(bus.req_ready), 128'(0));
        chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
        chk({tag, "_rsp_id"}, 128'(bus.rsp_id), 128'(0));
        chk({tag, "_rsp_hit"}, 128'(bus.rsp_hit), 128'(0));
        chk({tag, "_rsp_err"}, 128'(bus.rsp_err), 128'(0));
        chk({tag, "_bf_start"}, 128'(bus.bf_start), 128'(0));
        chk({tag, "_bf_ip_pro"}, 128'(bus.bf_ip_pro), 128'(0));
        chk({tag, "_bf_src_port"}, 128'(bus.bf_src_port), 128'(0));
        chk({tag, "_bf_dest_port"}, 128'(bus.bf_dest_port), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bf_tuple_t t1;
        int        got;
        int        n;

        reset         = 1'b0;
        req_valid     = '1;
        req_ip_pro    = '0;
        req_src_port  = '0;
        req_dest_port = '0;
        rsp_ready     = 1'b1;
        bf_readyRecv  = 1'b1;
        fm_en         = 1'b1;
        fm_delay      = 2;

        // reset state, with every requester asserting valid
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: single lookup from port 0, hit
        t1.ip_pro    = {32'hC0A9011E, 32'hC0A8011E, 8'h1E};
        t1.src_port  = 16'd16538;
        t1.dest_port = 16'd37281;
        send(0, t1, 1'b1, 1'b0, 1'b1);
        wait_drain(50);

        // restart pointer from 0 for the rotation test
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 2: all ports request continuously for 8 lookups
        for (int p = 0; p < NUM_REQ; p++) set_port(p, port_tuple(p));
        for (int k = 0; k < 8; k++) begin
            exp_gnt_q.push_back(k % 4);
            exp_bf_q.push_back(port_tuple(k % 4));
            exp_rsp_q.push_back(rsp_t'({2'(k % 4), 1'(((k % 4) % 2) == 0), 1'b0}));
        end
        req_valid = '1;
        got = 0;
        n   = 0;
        while (got < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.req_ready != '0) got++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        if (got < 8) flag("rotation_timeout");
        wait_drain(100);

        // 3: filter not ready for 10 cycles
        bf_readyRecv = 1'b0;
        send(3, port_tuple(3), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_bf_start", 128'(bus.bf_start), 128'(0));
            chk("stall_bf_tuple", {bus.bf_ip_pro, bus.bf_src_port, bus.bf_dest_port}, 128'(port_tuple(3)));
        end
        @(posedge clk); #1;
        bf_readyRecv = 1'b1;
        @(negedge clk);
        chk("first_ready_bf_start", 128'(bus.bf_start), 128'(1));
        @(posedge clk); #1;
        wait_drain(50);

        // 4: response consumer stalls; a second requester must wait
        rsp_ready = 1'b0;
        send(1, port_tuple(1), 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) flag("rsp_valid_timeout");
        @(posedge clk); #1;
        exp_gnt_q.push_back(2);
        exp_bf_q.push_back(port_tuple(2));
        exp_rsp_q.push_back(rsp_t'({2'd2, 1'b1, 1'b0}));
        set_port(2, port_tuple(2));
        req_valid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 128'(bus.rsp_valid), 128'(1));
            chk("hold_rsp_hit", 128'(bus.rsp_hit), 128'(0));
            chk("hold_rsp_id", 128'(bus.rsp_id), 128'(1));
            chk("hold_req_ready", 128'(bus.req_ready), 128'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("accept_cycle_req_ready", 128'(bus.req_ready), 128'(0));
        wait_grant(2, 10);
        wait_drain(50);

        // 5: reset while waiting for the filter result
        fm_en = 1'b0;
        send(0, port_tuple(0), 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!bus.bf_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bf_start) flag("bf_start_timeout");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        fm_en = 1'b1;
        @(posedge clk); #1;
        send(2, port_tuple(2), 1'b1, 1'b0, 1'b1);
        wait_drain(50);

`ifdef BF_ARB_TIMEOUT_EN
        // 6: filter answers only after the timeout has expired
        fm_delay = 80;
        send(0, port_tuple(0), 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!bus.bf_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.bf_start) flag("timeout_bf_start");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 200);
        chk("timeout_latency", 128'(n), 128'(65));
        @(posedge clk); #1;
        wait_drain(50);
        repeat (30) @(posedge clk);
        #1;
        fm_delay = 2;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
